// File: rtl/adc_capture_pkg.sv
// Shared widths, FSM state encoding and trigger-mode codes for the ADC capture engine.
package adc_capture_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned DEPTH      = 256;
  localparam int unsigned ADDR_WIDTH = 8;
  localparam int unsigned FREQ_WIDTH = 32;

  localparam logic [1:0] TRIG_IMMEDIATE = 2'd0;
  localparam logic [1:0] TRIG_RISING    = 2'd1;
  localparam logic [1:0] TRIG_FALLING   = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/adc_capture_engine_if.sv
// Config, ADC data, read-back and status bundle of the capture engine.
// ADC_CAPTURE_MINMAX_EN adds the sample_min/sample_max status signals.
interface adc_capture_engine_if;
  import adc_capture_pkg::*;

  logic                  capture_enable;
  logic [FREQ_WIDTH-1:0] sample_freq;
  logic [1:0]            trigger_mode;
  logic [DATA_WIDTH-1:0] trigger_level;
  logic                  capture_start;
  logic [DATA_WIDTH-1:0] adc_data;
  logic                  adc_clk;
  logic                  buf_rd_pulse;
  logic [DATA_WIDTH-1:0] buf_rd_data;
  logic                  capture_busy;
  logic                  capture_done;
`ifdef ADC_CAPTURE_MINMAX_EN
  logic [DATA_WIDTH-1:0] sample_min;
  logic [DATA_WIDTH-1:0] sample_max;

  modport master (
    output capture_enable, sample_freq, trigger_mode, trigger_level,
           capture_start, adc_data, buf_rd_pulse,
    input  adc_clk, buf_rd_data, capture_busy, capture_done, sample_min, sample_max
  );
  modport slave (
    input  capture_enable, sample_freq, trigger_mode, trigger_level,
           capture_start, adc_data, buf_rd_pulse,
    output adc_clk, buf_rd_data, capture_busy, capture_done, sample_min, sample_max
  );
`else
  modport master (
    output capture_enable, sample_freq, trigger_mode, trigger_level,
           capture_start, adc_data, buf_rd_pulse,
    input  adc_clk, buf_rd_data, capture_busy, capture_done
  );
  modport slave (
    input  capture_enable, sample_freq, trigger_mode, trigger_level,
           capture_start, adc_data, buf_rd_pulse,
    output adc_clk, buf_rd_data, capture_busy, capture_done
  );
`endif

endinterface

// File: rtl/adc_trigger_detect.sv
// Level-crossing trigger: compares the current sample against the previous strobed sample.
module adc_trigger_detect
  import adc_capture_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  strobe,
  input  logic [DATA_WIDTH-1:0] adc_q,
  input  logic [DATA_WIDTH-1:0] level,
  input  logic [1:0]            mode,
  output logic                  trig_c
);

  logic [DATA_WIDTH-1:0] prev_q;
  logic                  prev_valid;

  // prev_valid keeps edge modes quiet until a second strobe after arming
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q     <= '0;
      prev_valid <= 1'b0;
    end else if (clear) begin
      prev_valid <= 1'b0;
    end else if (strobe) begin
      prev_q     <= adc_q;
      prev_valid <= 1'b1;
    end
  end

  always_comb begin
    trig_c = 1'b1;
    case (mode)
      TRIG_IMMEDIATE: trig_c = 1'b1;
      TRIG_RISING:    trig_c = prev_valid && (prev_q < level) && (adc_q >= level);
      TRIG_FALLING:   trig_c = prev_valid && (prev_q > level) && (adc_q <= level);
      default:        trig_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/adc_capture_engine.sv
// Triggered ADC capture into a 256-point buffer with byte-wise read-back.
// Optional ADC_CAPTURE_MINMAX_EN tracks min/max of the captured samples.
module adc_capture_engine
  import adc_capture_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  adc_capture_engine_if.slave  bus
);

  state_e                state;
  logic [FREQ_WIDTH-1:0] phase_acc;
  logic [DATA_WIDTH-1:0] adc_q;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [FREQ_WIDTH:0]   acc_sum_c;
  logic                  active_c;
  logic                  strobe_c;
  logic                  sample_c;
  logic                  arm_c;
  logic                  trig_c;
  logic                  wr_en_c;
  logic                  rd_en_c;
  logic                  last_c;

  assign active_c  = (state == ARMED) || (state == CAPTURE);
  assign acc_sum_c = {1'b0, phase_acc} + {1'b0, bus.sample_freq};
  assign strobe_c  = active_c && acc_sum_c[FREQ_WIDTH];
  assign arm_c     = bus.capture_start && (bus.capture_enable || (state == DONE));
  // a strobe only counts when the engine is neither aborting nor restarting
  assign sample_c  = strobe_c && bus.capture_enable && !arm_c;
  assign wr_en_c   = sample_c && ((state == CAPTURE) || trig_c);
  assign rd_en_c   = (state == DONE) && bus.buf_rd_pulse && !bus.capture_start;
  assign last_c    = (wr_addr == ADDR_WIDTH'(DEPTH - 1));

  adc_trigger_detect u_trig (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (arm_c),
    .strobe (sample_c),
    .adc_q  (adc_q),
    .level  (bus.trigger_level),
    .mode   (bus.trigger_mode),
    .trig_c (trig_c)
  );

  // Buffer write port, no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_addr] <= adc_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       bus.buf_rd_data <= '0;
    else if (rd_en_c) bus.buf_rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      phase_acc        <= '0;
      adc_q            <= '0;
      wr_addr          <= '0;
      rd_addr          <= '0;
      bus.adc_clk      <= 1'b0;
      bus.capture_busy <= 1'b0;
      bus.capture_done <= 1'b0;
    end else begin
      adc_q <= bus.adc_data;
      if (arm_c) begin
        state            <= ARMED;
        phase_acc        <= '0;
        wr_addr          <= '0;
        rd_addr          <= '0;
        bus.adc_clk      <= 1'b0;
        bus.capture_busy <= 1'b1;
        bus.capture_done <= 1'b0;
      end else begin
        case (state)
          ARMED, CAPTURE: begin
            if (!bus.capture_enable) begin
              state            <= IDLE;
              bus.adc_clk      <= 1'b0;
              bus.capture_busy <= 1'b0;
            end else begin
              phase_acc   <= acc_sum_c[FREQ_WIDTH-1:0];
              bus.adc_clk <= acc_sum_c[FREQ_WIDTH-1];
              if (wr_en_c) begin
                wr_addr <= wr_addr + ADDR_WIDTH'(1);
                if (last_c) begin
                  state            <= DONE;
                  bus.adc_clk      <= 1'b0;
                  bus.capture_busy <= 1'b0;
                  bus.capture_done <= 1'b1;
                end else begin
                  state <= CAPTURE;
                end
              end
            end
          end
          DONE: begin
            if (rd_en_c) rd_addr <= rd_addr + ADDR_WIDTH'(1);
          end
          default: ;
        endcase
      end
    end
  end

`ifdef ADC_CAPTURE_MINMAX_EN
  // Running extremes of everything written since the last arm
  always_ff @(posedge clk) begin
    if (!rst_n || arm_c) begin
      bus.sample_min <= '1;
      bus.sample_max <= '0;
    end else if (wr_en_c) begin
      if (adc_q < bus.sample_min) bus.sample_min <= adc_q;
      if (adc_q > bus.sample_max) bus.sample_max <= adc_q;
    end
  end
`endif

endmodule
